// File: rtl/iob_sipo_deser.sv
// Serial-in, parallel-out deserializer: MSB-first bit stream to DATA_W-bit words with a valid/ready port.
// Optional macro IOB_SIPO_DESER_PARITY_EN appends one even-parity bit to every frame.
module iob_sipo_deser #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_en,
    input  logic              s_in,
    output logic [DATA_W-1:0] p_out,
    output logic              p_valid,
    input  logic              p_ready,
    output logic              busy,
    output logic              overrun,
    output logic              parity_err
);

`ifdef IOB_SIPO_DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam int              CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    // Returns 1 when data plus parity bit has odd weight, i.e. an even-parity violation.
    function automatic logic even_parity_err(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              last_s;
    logic              accept_s;
    logic              drop_s;
    logic [DATA_W-1:0] word_s;
    logic [DATA_W-1:0] p_out_r;
    logic              p_valid_r;
    logic              busy_r;
    logic              overrun_r;

    // Next-state of the assembly shift register and frame bit counter; clr wins over s_en.
    always_comb begin
        shift_next_s = shift_r;
        cnt_next_s   = cnt_r;
        last_s       = 1'b0;
        if (clr) begin
            shift_next_s = {DATA_W{1'b0}};
            cnt_next_s   = {CNT_W{1'b0}};
        end else if (s_en) begin
            shift_next_s = {shift_r[DATA_W-2:0], s_in};
            if (cnt_r == LAST_CNT) begin
                cnt_next_s = {CNT_W{1'b0}};
                last_s     = 1'b1;
            end else begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end
        end else begin
            last_s = 1'b0;
        end
    end

    // With parity the last sampled bit is the parity bit, so the word is already complete in shift_r.
`ifdef IOB_SIPO_DESER_PARITY_EN
    assign word_s = shift_r;
`else
    assign word_s = {shift_r[DATA_W-2:0], s_in};
`endif

    assign accept_s = last_s & (~p_valid_r | p_ready);
    assign drop_s   = last_s & p_valid_r & ~p_ready;

    // Assembly state, output word register, handshake and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r   <= {DATA_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            p_out_r   <= {DATA_W{1'b0}};
            p_valid_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            shift_r <= shift_next_s;
            cnt_r   <= cnt_next_s;
            busy_r  <= (cnt_next_s != {CNT_W{1'b0}});
            if (accept_s) begin
                p_out_r   <= word_s;
                p_valid_r <= 1'b1;
            end else if (p_valid_r && p_ready) begin
                p_valid_r <= 1'b0;
            end else begin
                p_valid_r <= p_valid_r;
            end
            if (clr) begin
                overrun_r <= 1'b0;
            end else if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

`ifdef IOB_SIPO_DESER_PARITY_EN
    logic parity_err_r;

    // Parity status travels with the accepted word; dropped words leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_r <= 1'b0;
        end else if (accept_s) begin
            parity_err_r <= even_parity_err(shift_r, s_in);
        end else begin
            parity_err_r <= parity_err_r;
        end
    end

    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

    assign p_out   = p_out_r;
    assign p_valid = p_valid_r;
    assign busy    = busy_r;
    assign overrun = overrun_r;

endmodule

// File: tb/tb_iob_sipo_deser.sv
// Directed self-checking bench for iob_sipo_deser with DATA_W=8 and a queue of expected words.
module tb_iob_sipo_deser;

    localparam int DATA_W = 8;
`ifdef IOB_SIPO_DESER_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clr = 1'b0;
    logic              s_en = 1'b0;
    logic              s_in = 1'b0;
    logic [DATA_W-1:0] p_out;
    logic              p_valid;
    logic              p_ready = 1'b0;
    logic              busy;
    logic              overrun;
    logic              parity_err;

    int                n_cmp = 0;
    int                n_mis = 0;
    logic [DATA_W-1:0] sb[$];
    logic [DATA_W-1:0] last_exp = '0;

    iob_sipo_deser #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .s_en(s_en), .s_in(s_in),
        .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready), .busy(busy),
        .overrun(overrun), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame MSB first; the parity bit (if built) is even parity, flipped by bad_par.
    task automatic send_frame(input logic [DATA_W-1:0] w, input bit gap, input bit chk_busy,
                              input bit ready_on_last, input bit bad_par);
        logic [DATA_W:0] fbits;
`ifdef IOB_SIPO_DESER_PARITY_EN
        fbits = {w, (^w) ^ bad_par};
`else
        fbits = {1'b0, w};
`endif
        for (int i = FRAME_LEN - 1; i >= 0; i--) begin
            if (i == 0 && ready_on_last) p_ready = 1'b1;
            s_en = 1'b1;
            s_in = fbits[i];
            tick();
            s_en = 1'b0;
            if (chk_busy && i != 0) chk("busy_mid", {63'd0, busy}, 64'd1);
            if (gap && i != 0) begin
                tick();
                if (chk_busy) chk("busy_gap", {63'd0, busy}, 64'd1);
            end
        end
    endtask

    task automatic send_partial(input logic [3:0] bits);
        for (int i = 3; i >= 0; i--) begin
            s_en = 1'b1;
            s_in = bits[i];
            tick();
        end
        s_en = 1'b0;
    endtask

    // Pops the next expected word and checks the output port against it.
    task automatic check_word(input string tag, input logic perr_exp);
        n_cmp++;
        assert (sb.size() != 0) else begin
            n_mis++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb.size() != 0) last_exp = sb.pop_front();
        chk({tag, "_valid"}, {63'd0, p_valid}, 64'd1);
        chk({tag, "_out"}, {56'd0, p_out}, {56'd0, last_exp});
        chk({tag, "_perr"}, {63'd0, parity_err}, {63'd0, perr_exp});
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_out", {56'd0, p_out}, 64'd0);
        chk("rst_valid", {63'd0, p_valid}, 64'd0);
        chk("rst_ovr", {63'd0, overrun}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_perr", {63'd0, parity_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // back-to-back bits, consumer ready
        p_ready = 1'b1;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("a5", 1'b0);
        tick();
        chk("a5_drop", {63'd0, p_valid}, 64'd0);

        // gapped bits with busy tracking
        chk("3c_busy0", {63'd0, busy}, 64'd0);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("3c_busy_end", {63'd0, busy}, 64'd0);
        check_word("3c", 1'b0);
        tick();
        chk("3c_drop", {63'd0, p_valid}, 64'd0);

        // overrun while consumer stalls, then clr
        p_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("11", 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_hold_out", {56'd0, p_out}, {56'd0, last_exp});
        chk("ovr_valid", {63'd0, p_valid}, 64'd1);
        chk("ovr_flag", {63'd0, overrun}, 64'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovr", {63'd0, overrun}, 64'd0);
        chk("clr_out", {56'd0, p_out}, 64'h11);
        chk("clr_valid", {63'd0, p_valid}, 64'd1);
        p_ready = 1'b1;
        tick();
        chk("clr_consume", {63'd0, p_valid}, 64'd0);

        // delivery coinciding with consumption
        p_ready = 1'b0;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("11b", 1'b0);
        sb.push_back(8'h77);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("77", 1'b0);
        chk("77_ovr", {63'd0, overrun}, 64'd0);
        tick();
        chk("77_drop", {63'd0, p_valid}, 64'd0);

        // reset mid-frame discards partial bits
        send_partial(4'b1011);
        chk("part_busy", {63'd0, busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_out", {56'd0, p_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sb.push_back(8'hF0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("f0_rst", 1'b0);
        tick();

        // clr mid-frame discards partial bits
        send_partial(4'b1010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_busy", {63'd0, busy}, 64'd0);
        sb.push_back(8'h0F);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("0f_clr", 1'b0);
        tick();

`ifdef IOB_SIPO_DESER_PARITY_EN
        // parity good then parity bad
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("par_ok", 1'b0);
        tick();
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
        check_word("par_bad", 1'b1);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/iob_sipo_deser.md
Name: iob_sipo_deser

Overview:
- Serial-in, parallel-out deserializer: the receive-end counterpart of the team's parallel-in, serial-out shift register.
- Accepts one bit per enabled clock, MSB first, and assembles a DATA_W-bit word.
- Presents each completed word on a registered parallel port with a valid/ready handshake.
- Sits between a serial link front-end and a word-oriented consumer (FIFO, CSR bank).

Parameters:
- DATA_W, 32, word width in bits; legal range 2..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous frame clear; restarts word assembly.
- s_en  input  1  serial bit valid; s_in is sampled when high.
- s_in  input  1  serial data bit, MSB first.
- p_out  output  DATA_W  assembled word, registered.
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  consumer accepts p_out when p_valid and p_ready are both high.
- busy  output  1  a partial frame is in progress (bit count != 0).
- overrun  output  1  sticky: a completed word was dropped.
- parity_err  output  1  parity status of the word on p_out.

Behaviour:
- Reset (rst_n low, asynchronous): shift register = 0, bit counter = 0, p_out = 0, p_valid = 0, overrun = 0, parity_err = 0, busy = 0.
- Reset asserted mid-frame discards the partial frame. After reset release the first s_en bit is bit 0 of a new frame.
- Shift register: on s_en, shift left and insert s_in at bit 0. The first received bit ends up at p_out[DATA_W-1].
- Bit counter:
  - Width $clog2(FRAME_LEN+1); FRAME_LEN = DATA_W, or DATA_W+1 with the optional feature.
  - Increments on s_en.
  - On the last bit it wraps to 0 and the frame completes. A completed frame is a "delivery".
- Delivery is accepted when p_valid = 0, or when p_valid = 1 and p_ready = 1 in the same cycle. On acceptance:
  - p_out <= the completed word, including the bit sampled this cycle.
  - p_valid <= 1.
  - Latency: p_valid is high in the cycle after the edge that samples the last bit.
- Delivery with p_valid = 1 and p_ready = 0: the word is discarded, overrun <= 1, and p_out/p_valid are unchanged. The counter still wraps, so framing is preserved.
- Handshake: p_valid = 1 with p_ready = 1 and no delivery in that cycle clears p_valid the next cycle.
- p_out is stable while p_valid = 1 and the word has not been consumed.
- clr:
  - Takes priority over s_en. Sets counter = 0, shift register = 0, overrun = 0.
  - Does not touch p_out, p_valid or parity_err.
  - A delivery in the same cycle as clr is suppressed.
- busy: combinational (counter != 0).
- overrun: cleared only by clr or reset.
- s_en with p_ready held low never stalls the serial side.

Optional Feature:
- Macro: IOB_SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is DATA_W data bits followed by one even-parity bit.
  - The delivery point is the parity bit. The parity bit is not stored in p_out.
  - parity_err is loaded with XOR(data bits, parity bit) together with p_out; 1 means parity error.
  - A dropped word (overrun) does not update parity_err.
- Undefined:
  - Frames are DATA_W bits.
  - parity_err is constant 0.
  - The port is present in both builds.

Test Plan:
- DATA_W=8, reset, then 8 consecutive s_en bits 1,0,1,0,0,1,0,1 with p_ready=1 -> p_out=0xA5 and p_valid=1 exactly one cycle after the 8th bit edge; p_valid drops the next cycle.
- Bits with gaps (s_en toggling 1,0,1,...) to send 0x3C -> busy=1 from bit 1 to bit 7; p_out=0x3C; busy=0 after the 8th bit.
- p_ready=0, send 0x11 then 0x22 -> p_out holds 0x11, overrun=1, p_valid stays 1; then pulse clr -> overrun=0 and p_out still 0x11; p_ready=1 -> p_valid=0.
- p_valid=1 for 0x11, last bit of 0x77 arrives in the same cycle as p_ready=1 -> p_out=0x77 next cycle, p_valid stays 1, overrun=0.
- Send 4 bits, assert rst_n=0 mid-frame, release, send 0xF0 -> p_out=0xF0 (no stale bits). Repeat using clr instead of reset -> same result.
- With IOB_SIPO_DESER_PARITY_EN: send 0xA5 followed by parity 0 -> parity_err=0; send 0xA5 followed by parity 1 -> parity_err=1, p_out=0xA5 in both cases.
